d_latch1: RTL and testbench

- Clock-synchronous emulation of a level-sensitive D latch with an active-low reset.
- While enable is high, the stored value follows the data input. While enable is low, it holds.
- Used wherever a latch-style hold register is needed but the design must stay fully synchronous (no true latches in the netlist).
- Optional combinational bypass gives same-cycle transparency, matching true-latch timing at the output.

---
 rtl/d_latch1.sv | 43 ++++
 tb/tb_d_latch1.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/d_latch1.sv
// Clock-synchronous stand-in for a level-sensitive D latch: loads d on every
// rising edge with en high, holds otherwise, optional same-cycle bypass to q.
module d_latch1 #(
    parameter int               WIDTH       = 1,
    parameter bit               TRANSPARENT = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             loaded
);

    logic [WIDTH-1:0] r_q;
    logic             r_loaded;

    // Reset is tested first so X on en/d during reset never reaches the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_q      <= RESET_VALUE;
            r_loaded <= 1'b0;
        end else if (en) begin
            r_q      <= d;
            r_loaded <= 1'b1;
        end
    end

    generate
        if (TRANSPARENT) begin : g_bypass
            logic w_pass;
            // rstn gates the bypass so reset also blanks the transparent path.
            assign w_pass = en && rstn;
            assign q      = w_pass ? d : r_q;
        end else begin : g_reg_only
            assign q = r_q;
        end
    endgenerate

    assign loaded = r_loaded;

endmodule

// File: tb/tb_d_latch1.sv
// Directed bench for d_latch1: a 1-bit registered instance and a 4-bit
// transparent instance share en/rstn and are checked side by side.
module tb_d_latch1;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [3:0] d;
    logic       q_r;
    logic       ld_r;
    logic [3:0] q_t;
    logic       ld_t;

    int n_checks;
    int n_pass;

    // reference state for the randomly paced section
    logic [3:0] m_q;
    logic       m_ld;

    d_latch1 #(.WIDTH(1), .TRANSPARENT(1'b0), .RESET_VALUE(1'b0)) u_dut_r (
        .clk    (clk),
        .rstn   (rstn),
        .d      (d[0]),
        .en     (en),
        .q      (q_r),
        .loaded (ld_r)
    );

    d_latch1 #(.WIDTH(4), .TRANSPARENT(1'b1), .RESET_VALUE(4'h5)) u_dut_t (
        .clk    (clk),
        .rstn   (rstn),
        .d      (d),
        .en     (en),
        .q      (q_t),
        .loaded (ld_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // advance one edge; the model samples the same inputs the DUTs see
    task automatic step();
        if (!rstn) begin
            m_q  = 4'h5;
            m_ld = 1'b0;
        end else if (en) begin
            m_q  = d;
            m_ld = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] tv [4];
        int         gap;
        n_checks = 0;
        n_pass   = 0;
        m_q      = 4'h0;
        m_ld     = 1'b0;
        tv[0] = 4'h2; tv[1] = 4'h3; tv[2] = 4'h6; tv[3] = 4'h7;

        // reset dominates en for two edges
        rstn = 1'b0; en = 1'b1; d = 4'hF;
        #1;
        step();
        step();
        chk("rst_q_r",  {31'b0, q_r},  32'h0);
        chk("rst_ld_r", {31'b0, ld_r}, 32'h0);
        chk("rst_q_t",  {28'b0, q_t},  32'h5);
        chk("rst_ld_t", {31'b0, ld_t}, 32'h0);

        rstn = 1'b1; en = 1'b0;
        #1;
        chk("rel_hold_q_t_comb", {28'b0, q_t}, 32'h5);
        step();
        chk("rel_q_r",  {31'b0, q_r},  32'h0);
        chk("rel_ld_r", {31'b0, ld_r}, 32'h0);
        chk("rel_q_t",  {28'b0, q_t},  32'h5);

        // load sequence: registered copy lags by one edge, bypass is immediate
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = tv[i];
            #1;
            chk("xp_q_t_comb", {28'b0, q_t}, {28'b0, tv[i]});
            chk("xp_q_r_prev", {31'b0, q_r}, (i == 0) ? 32'h0 : {31'b0, tv[i-1][0]});
            step();
            chk("xp_q_r",  {31'b0, q_r},  {31'b0, tv[i][0]});
            chk("xp_ld_r", {31'b0, ld_r}, 32'h1);
            chk("xp_q_t",  {28'b0, q_t},  {28'b0, tv[i]});
        end

        // hold while d wiggles
        d = 4'h9;
        step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = i[3:0];
            #1;
            chk("hold_q_t_comb", {28'b0, q_t}, 32'h9);
            step();
            chk("hold_q_r", {31'b0, q_r}, 32'h1);
            chk("hold_q_t", {28'b0, q_t}, 32'h9);
        end

        // randomly paced en inversions against the reference model
        for (int i = 0; i < 5; i++) begin
            en  = ~en;
            d   = i[3:0];
            gap = $urandom_range(0, 7);
            #1;
            $display("t=%0t en=%0b d=%h q_r=%0b q_t=%h", $time, en, d, q_r, q_t);
            chk("rnd_q_t_comb", {28'b0, q_t}, en ? {28'b0, d} : {28'b0, m_q});
            for (int k = 0; k < gap; k++) begin
                step();
                $display("t=%0t en=%0b d=%h q_r=%0b q_t=%h", $time, en, d, q_r, q_t);
                chk("rnd_q_r",  {31'b0, q_r},  {31'b0, m_q[0]});
                chk("rnd_q_t",  {28'b0, q_t},  en ? {28'b0, d} : {28'b0, m_q});
                chk("rnd_ld_t", {31'b0, ld_t}, {31'b0, m_ld});
            end
        end

        // mid-operation reset, including X on the inputs while reset is low
        en = 1'b1; d = 4'hB;
        step();
        chk("mid_pre_q_r", {31'b0, q_r}, 32'h1);
        chk("mid_pre_q_t", {28'b0, q_t}, 32'hB);
        rstn = 1'b0; d = 4'h3;
        #1;
        chk("mid_bypass_off", {28'b0, q_t}, 32'hB);
        step();
        chk("mid_q_r",  {31'b0, q_r},  32'h0);
        chk("mid_ld_r", {31'b0, ld_r}, 32'h0);
        chk("mid_q_t",  {28'b0, q_t},  32'h5);
        chk("mid_ld_t", {31'b0, ld_t}, 32'h0);
        en = 1'bx; d = 4'bxxxx;
        #1;
        chk("x_q_t_comb", {28'b0, q_t}, 32'h5);
        step();
        chk("x_q_r", {31'b0, q_r}, 32'h0);
        chk("x_q_t", {28'b0, q_t}, 32'h5);
        chk("x_ld_t", {31'b0, ld_t}, 32'h0);

        rstn = 1'b1; en = 1'b1; d = 4'hD;
        #1;
        chk("rl_q_t_comb", {28'b0, q_t}, 32'hD);
        chk("rl_q_r_pre",  {31'b0, q_r}, 32'h0);
        step();
        chk("rl_q_r",  {31'b0, q_r},  32'h1);
        chk("rl_ld_r", {31'b0, ld_r}, 32'h1);
        chk("rl_q_t",  {28'b0, q_t},  32'hD);

        // en toggling every edge with d changing on each
        en = 1'b0; d = 4'h2;
        step();
        chk("tg0_q_t", {28'b0, q_t}, 32'hD);
        chk("tg0_q_r", {31'b0, q_r}, 32'h1);
        en = 1'b1; d = 4'h4;
        step();
        chk("tg1_q_r", {31'b0, q_r}, 32'h0);
        en = 1'b0; d = 4'h1;
        #1;
        chk("tg2_q_t_comb", {28'b0, q_t}, 32'h4);
        step();
        chk("tg2_q_r", {31'b0, q_r}, 32'h0);
        chk("tg2_q_t", {28'b0, q_t}, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
